// File: rtl/slant_rx_multi.sv
// slant_rx_multi: multi-channel slant-link receiver with ch0 bit-timing recovery, sync detect and lock-step payload deserialiser
module slant_rx_multi #(
  parameter int CH = 4,
  parameter int SAMPLE_W = 8,
  parameter logic [SAMPLE_W-1:0] THRESH = 8'h7f,
  parameter int CNT_W = 8,
  parameter int DEF_BIT_TIME = 24,
  parameter int MIN_BIT_TIME = 4,
  parameter int MAX_BIT_TIME = 36,
  parameter int TRAIN_EDGES = 4,
  parameter int LOSS_BITS = 64,
  parameter int SYNC_W = 24,
  parameter logic [SYNC_W-1:0] SYNC_EVEN = 24'haab155,
  parameter logic [SYNC_W-1:0] SYNC_ODD = 24'haa8d55,
  parameter logic [SYNC_W-1:0] SYNC_LINE = 24'h00a355,
  parameter int PAYLOAD_W = 8,
  parameter int LINE_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [CH*SAMPLE_W-1:0]  rx_data,
  output logic [CH*PAYLOAD_W-1:0] out_data,
  output logic                    out_valid,
  output logic                    out_sof,
  output logic                    out_sol,
  output logic                    out_field,
  output logic                    locked,
  output logic [CNT_W-1:0]        bit_time,
  output logic                    lock_lost
);
  localparam int TB = $clog2(TRAIN_EDGES);
  localparam int LW = $clog2(LOSS_BITS + 1);
  localparam int BW = PAYLOAD_W > 1 ? $clog2(PAYLOAD_W) : 1;
  localparam int WW = LINE_WORDS > 1 ? $clog2(LINE_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, TRAIN, LOCKED} tState_e;
  typedef enum logic {HUNT, DATA} dState_e;
  tState_e tState, tNext;
  dState_e dState, dNext;
  logic [CH-1:0] slice, sQ, sQQ;
  logic edge0, inRange, trainDone, wrap, lossHit, strobe;
  logic [CNT_W-1:0] intCnt, bitCnt;
  logic [CNT_W+TB-1:0] sum, sumNext;
  logic [TB:0] trainCnt;
  logic [LW-1:0] lossCnt;
  logic [SYNC_W-1:0] syncReg, syncNext;
  logic [CH-1:0][PAYLOAD_W-1:0] shReg, shNext;
  logic [BW-1:0] dfBit;
  logic [WW-1:0] wordCnt;
  logic isEven, isOdd, isLine, match, wordDone, lastWord, sofPend, solPend;
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      slice[i] = rx_data[i*SAMPLE_W +: SAMPLE_W] > THRESH;
      shNext[i] = {shReg[i][PAYLOAD_W-2:0], sQ[i]};
    end
  end
  assign edge0 = sQ[0] ^ sQQ[0];
  assign inRange = intCnt >= CNT_W'(MIN_BIT_TIME) && intCnt <= CNT_W'(MAX_BIT_TIME);
  assign sumNext = sum + (CNT_W+TB)'(intCnt);
  assign trainDone = tState == TRAIN && edge0 && inRange && trainCnt == (TB+1)'(TRAIN_EDGES - 1);
  assign wrap = bitCnt == bit_time - CNT_W'(1);
  assign lossHit = tState == LOCKED && wrap && !edge0 && lossCnt == LW'(LOSS_BITS - 1);
  assign strobe = tState == LOCKED && bitCnt == (bit_time >> 1) && !edge0;
  assign locked = tState == LOCKED;
  assign syncNext = {syncReg[SYNC_W-2:0], sQ[0]};
  assign isEven = syncNext == SYNC_EVEN;
  assign isOdd = syncNext == SYNC_ODD;
  assign isLine = syncNext == SYNC_LINE;
  assign match = strobe && dState == HUNT && (isEven || isOdd || isLine);
  assign wordDone = strobe && dState == DATA && dfBit == BW'(PAYLOAD_W - 1);
  assign lastWord = wordDone && wordCnt == WW'(LINE_WORDS - 1);
  always_comb begin
    tNext = lossHit ? IDLE : trainDone ? LOCKED : (tState == IDLE && edge0) ? TRAIN : tState;
    dNext = lossHit ? HUNT : match ? DATA : lastWord ? HUNT : dState;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      tState <= IDLE;
      dState <= HUNT;
    end else begin
      tState <= tNext;
      dState <= dNext;
    end
  // An out-of-range interval restarts training with the current edge as the new start
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      sQ <= '0;
      sQQ <= '0;
      intCnt <= '0;
      sum <= '0;
      trainCnt <= '0;
      bit_time <= CNT_W'(DEF_BIT_TIME);
      bitCnt <= '0;
      lossCnt <= '0;
      lock_lost <= 1'b0;
    end else begin
      sQ <= slice;
      sQQ <= sQ;
      intCnt <= edge0 ? CNT_W'(1) : &intCnt ? intCnt : intCnt + CNT_W'(1);
      sum <= tState != TRAIN ? '0 : !edge0 ? sum : inRange ? sumNext : '0;
      trainCnt <= tState != TRAIN ? '0 : !edge0 ? trainCnt : inRange ? trainCnt + (TB+1)'(1) : '0;
      bit_time <= lossHit ? CNT_W'(DEF_BIT_TIME) : trainDone ? CNT_W'(sumNext >> TB) : bit_time;
      bitCnt <= tState != LOCKED || edge0 || wrap ? '0 : bitCnt + CNT_W'(1);
      lossCnt <= tState != LOCKED || edge0 ? '0 : wrap ? lossCnt + LW'(1) : lossCnt;
      lock_lost <= lossHit;
    end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      shReg <= '0;
      syncReg <= '0;
      dfBit <= '0;
      wordCnt <= '0;
      sofPend <= 1'b0;
      solPend <= 1'b0;
      out_field <= 1'b0;
      out_valid <= 1'b0;
      out_sof <= 1'b0;
      out_sol <= 1'b0;
      out_data <= '0;
    end else begin
      if (strobe) shReg <= shNext;
      syncReg <= lastWord || lossHit ? '0 : strobe ? syncNext : syncReg;
      dfBit <= match || wordDone ? '0 : strobe && dState == DATA ? dfBit + BW'(1) : dfBit;
      wordCnt <= match ? '0 : wordDone ? wordCnt + WW'(1) : wordCnt;
      sofPend <= match ? isEven || isOdd : wordDone ? 1'b0 : sofPend;
      solPend <= match || (solPend && !wordDone);
      out_field <= match && (isEven || isOdd) ? !isEven : out_field;
      out_valid <= wordDone;
      out_sof <= wordDone && sofPend;
      out_sol <= wordDone && solPend;
      if (wordDone) out_data <= shNext;
    end
endmodule

// File: tb/tb_slant_rx_multi.sv
// tb_slant_rx_multi: scoreboard bench for slant_rx_multi covering training, sync/deframing, lock loss and async reset
module tb_slant_rx_multi;
  localparam int CH = 4;
  localparam int BT = 24;
  localparam logic [23:0] S_EVEN = 24'haab155;
  localparam logic [23:0] S_ODD = 24'haa8d55;
  localparam logic [23:0] S_LINE = 24'h00a355;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [CH*8-1:0] rx_data = {CH{8'h7f}};
  logic [CH*8-1:0] out_data;
  logic out_valid, out_sof, out_sol, out_field, locked, lock_lost;
  logic [7:0] bit_time;
  int nCmp = 0;
  int nErr = 0;
  int nValid = 0;
  int nLost = 0;
  logic [34:0] sb[$];
  always #5 clk = ~clk;
  slant_rx_multi dut (
    .clk(clk),
    .rstn(rstn),
    .rx_data(rx_data),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_sof(out_sof),
    .out_sol(out_sol),
    .out_field(out_field),
    .locked(locked),
    .bit_time(bit_time),
    .lock_lost(lock_lost)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCmp++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask
  // ch0 swings full scale; other channels sit just either side of the threshold
  task automatic sendBit(input logic [CH-1:0] b);
    for (int c = 0; c < CH; c++)
      rx_data[c*8 +: 8] = b[c] ? (c == 0 ? 8'hff : 8'h80) : (c == 0 ? 8'h00 : 8'h7f);
    hold(BT);
  endtask
  task automatic sendSync(input logic [23:0] p);
    for (int k = 23; k >= 0; k--) sendBit({3'b000, p[k]});
  endtask
  task automatic sendWord(input logic [31:0] w, input logic sof, input logic sol, input logic field);
    sb.push_back({field, sol, sof, w});
    for (int k = 7; k >= 0; k--) sendBit({w[24+k], w[16+k], w[8+k], w[k]});
  endtask
  always @(negedge clk)
    if (rstn) begin
      if (out_valid) begin
        nValid++;
        if (sb.size() == 0) chk("extra_valid", out_valid, 1'b0);
        else chk("word", {out_field, out_sol, out_sof, out_data}, sb.pop_front());
      end
      if (lock_lost) nLost++;
    end
  initial begin
    int iv[7] = '{24, 24, 40, 30, 30, 30, 30};
    logic [31:0] w;
    hold(3);
    chk("rst_bit_time", bit_time, 24);
    chk("rst_locked", locked, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_lock_lost", lock_lost, 0);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) sendBit({3'b000, i % 2 == 0});
    chk("lock_4edges", locked, 0);
    sendBit(4'b0001);
    chk("lock_5edges", locked, 1);
    chk("bit_time_24", bit_time, 24);
    for (int i = 5; i < 10; i++) sendBit({3'b000, i % 2 == 0});
    chk("no_valid_alt", nValid, 0);
    sendSync(S_EVEN);
    sendWord(32'hf00f3ca5, 1'b1, 1'b1, 1'b0);
    repeat (3) sendWord($urandom, 1'b0, 1'b0, 1'b0);
    sendSync(S_ODD);
    sendWord($urandom, 1'b1, 1'b1, 1'b1);
    repeat (3) sendWord($urandom, 1'b0, 1'b0, 1'b1);
    sendSync(S_LINE);
    sendWord($urandom, 1'b0, 1'b1, 1'b1);
    repeat (3) sendWord($urandom, 1'b0, 1'b0, 1'b1);
    // even-frame sync carried inside the payload must not restart the line
    sendSync(S_LINE);
    w = $urandom; w[7:0] = 8'haa; sendWord(w, 1'b0, 1'b1, 1'b1);
    w = $urandom; w[7:0] = 8'hb1; sendWord(w, 1'b0, 1'b0, 1'b1);
    w = $urandom; w[7:0] = 8'h55; sendWord(w, 1'b0, 1'b0, 1'b1);
    w = $urandom; w[7:0] = 8'h00; sendWord(w, 1'b0, 1'b0, 1'b1);
    chk("valid_count", nValid, 16);
    chk("sb_drained", sb.size(), 0);
    sendSync(S_ODD);
    sendWord($urandom | 32'h1, 1'b1, 1'b1, 1'b1);
    sendBit(4'b1111);
    sendBit(4'b0000);
    hold(5);
    rstn = 1'b0;
    #1;
    chk("rstmid_data", out_data, 0);
    chk("rstmid_field", out_field, 0);
    chk("rstmid_locked", locked, 0);
    chk("rstmid_valid_count", nValid, 17);
    rx_data = {CH{8'h7f}};
    hold(3);
    rstn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data[7:0] = rx_data[7:0] == 8'h80 ? 8'h7f : 8'h80;
      if (i < 7) begin
        hold(iv[i]);
        if (i == 6) chk("no_lock_after_restart", locked, 0);
      end
    end
    hold(10);
    chk("lock_30", locked, 1);
    chk("bit_time_30", bit_time, 30);
    hold(1850);
    chk("still_locked", locked, 1);
    chk("no_early_loss", nLost, 0);
    hold(150);
    chk("lost_locked", locked, 0);
    chk("lost_pulses", nLost, 1);
    chk("bit_time_def", bit_time, 24);
    chk("no_valid_after_reset", nValid, 17);
    chk("sb_empty_end", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule

// File: doc/slant_rx_multi.md
# slant_rx_multi

Parametrised multi-channel slant-link receiver for the drone camera downlink. It slices CH sample streams against a threshold and recovers bit timing from channel 0 by averaging trained edge intervals. Sync words (even frame, odd frame, line) are detected on channel 0. Each line's payload is then deserialised from all channels in lock-step into parallel words with frame/line markers. It sits between the ADC sample front end and the frame reassembly/video write path.

## Interface
- CH, 4, number of channels; channel 0 is the timing/sync reference
- SAMPLE_W, 8, sample width per channel
- THRESH, 8'h7f, a sample is logic 1 when it is strictly greater than THRESH
- CNT_W, 8, width of the interval and bit counters
- DEF_BIT_TIME, 24, bit_time value after reset and after lock loss
- MIN_BIT_TIME, 4 and MAX_BIT_TIME, 36, accepted training interval range (inclusive)
- TRAIN_EDGES, 4, training intervals averaged; must be a power of 2
- LOSS_BITS, 64, bit periods without a channel-0 edge before lock is dropped
- SYNC_W, 24, sync word length
- SYNC_EVEN, 24'haab155; SYNC_ODD, 24'haa8d55; SYNC_LINE, 24'h00a355
- PAYLOAD_W, 8, bits per output word per channel
- LINE_WORDS, 4, words delivered after each sync match
- clk in 1: clock
- rstn in 1: reset, asynchronous, active-low
- rx_data in CH*SAMPLE_W: channel c at [c*SAMPLE_W +: SAMPLE_W]
- out_data out CH*PAYLOAD_W: channel c word at [c*PAYLOAD_W +: PAYLOAD_W], first received bit is the MSB
- out_valid out 1: one-cycle word strobe; there is no backpressure
- out_sof out 1: qualifies out_valid; first word after SYNC_EVEN or SYNC_ODD
- out_sol out 1: qualifies out_valid; first word after any sync match
- out_field out 1: 0 after SYNC_EVEN, 1 after SYNC_ODD; held until the next frame sync
- locked out 1: timing recovered
- bit_time out CNT_W: current bit period in clk cycles
- lock_lost out 1: one-cycle pulse when locked falls

## Operation
- Front end, all channels:
  - Sliced bit is registered to s_q, then delayed to s_qq.
  - Channel-0 edge = s_q[0] ^ s_qq[0].
- Interval counter:
  - Loads 1 on an edge, otherwise increments and saturates at all-ones.
  - Its value at an edge is the interval in cycles.
- Timing FSM:
  - IDLE: on the first edge, go to TRAIN.
  - TRAIN: each edge captures the interval.
    - An interval outside [MIN_BIT_TIME, MAX_BIT_TIME] clears accumulated intervals and stays in TRAIN, with this edge as the new start.
    - After TRAIN_EDGES accepted intervals: bit_time <= sum >> log2(TRAIN_EDGES) (sum width CNT_W+log2(TRAIN_EDGES), truncating), then go to LOCKED.
  - LOCKED:
    - Bit counter runs 0..bit_time-1 and wraps; an edge forces it to 0, and the edge wins over the wrap.
    - strobe = (bit counter == bit_time>>1) and no edge this cycle.
    - An edge-free bit counter counts wraps; reaching LOSS_BITS pulses lock_lost and goes to IDLE.
    - On lock loss: bit_time reverts to DEF_BIT_TIME and the deframer returns to HUNT.
- Deframer FSM (advances only on strobe; each strobe shifts s_q of every channel into its shift register):
  - HUNT: compares the channel-0 SYNC_W register, with priority EVEN > ODD > LINE.
    - On a match: set the sof/sol pending flags, update out_field (frame syncs only), clear word and bit counters, go to DATA.
  - DATA: sync patterns are ignored.
    - Every PAYLOAD_W strobes, register all channel words into out_data and pulse out_valid, with the pending flags on the first word only.
    - After LINE_WORDS words, go to HUNT and clear the channel-0 sync register.

## Timing
- Reset value of every output is 0, except bit_time = DEF_BIT_TIME.
- Sample to s_q: 1 cycle. Edge is visible 2 cycles after the input crosses THRESH.
- locked rises the cycle after the edge that completes training.
- out_valid is high the cycle after the strobe that shifts in a word's last bit. out_data holds until the next out_valid.
- Reset mid-word discards the partial word and the lock. No out_valid is produced until relock plus a new sync.

## Test plan
- Channel 0 alternating 0xFF/0x00 every 24 cycles:
  - locked=1 after the 5th edge, bit_time=24.
  - No out_valid occurs.
- Training intervals of 24, 24, 40, then 4×30:
  - The 40 restarts training.
  - Lock occurs with bit_time=30.
- Lock at 24, send SYNC_EVEN on ch0, then words 0xA5, 0x3C, 0x0F, 0xF0 on ch0..3:
  - out_valid with out_data=32'hF00F3CA5, out_sof=1, out_sol=1, out_field=0.
  - 3 more words follow with sof=sol=0.
- SYNC_ODD then 4 words:
  - out_field=1.
  - Then SYNC_LINE yields out_sol=1, out_sof=0, field still 1.
- A sync pattern embedded in DATA payload is ignored:
  - Exactly LINE_WORDS out_valid pulses per sync.
- Hold ch0 constant for 64 bit periods:
  - lock_lost pulses once, locked=0, bit_time=24.
  - rstn low mid-word clears all outputs immediately.
